// File: rtl/gray_wptr_ctrl.sv
// Write-side pointer controller for an asynchronous FIFO: binary/Gray write pointer, read-pointer synchronizer, full flag.
// Optional feature macro: GRAY_WPTR_CTRL_ALMOST_FULL_EN adds the registered o_almost_full output.
module gray_wptr_ctrl #(
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_THRESH = 2**ADDR_WIDTH - 2
) (
  input  logic                  i_clock,
  input  logic                  i_aresetn,
  input  logic                  i_push,
  input  logic [ADDR_WIDTH:0]   i_rptr_gray,
  output logic                  o_wen,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [ADDR_WIDTH:0]   o_wptr_gray,
  output logic                  o_full
`ifdef GRAY_WPTR_CTRL_ALMOST_FULL_EN
  ,
  output logic                  o_almost_full
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ {1'b0, b[PW-1:1]};
  endfunction

`ifdef GRAY_WPTR_CTRL_ALMOST_FULL_EN
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
`endif

  logic          accept_s;
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] rq1_q, rq1_d;
  logic [PW-1:0] rq2_q, rq2_d;
  logic          full_q, full_d;
`ifdef GRAY_WPTR_CTRL_ALMOST_FULL_EN
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] fill_s;
  logic          almost_full_q, almost_full_d;
`endif

  // Next-state: accept gating, pointer advance and flag evaluation against the synchronized read pointer
  always_comb begin
    // Gating with reset keeps the storage write strobe quiet while reset is held.
    accept_s = i_push & ~full_q & i_aresetn;
    wbin_d   = wbin_q + {{ADDR_WIDTH{1'b0}}, accept_s};
    wgray_d  = bin2gray(wbin_d);
    rq1_d    = i_rptr_gray;
    rq2_d    = rq1_q;
    full_d   = (wgray_d == {~rq2_q[PW-1:PW-2], rq2_q[PW-3:0]});
`ifdef GRAY_WPTR_CTRL_ALMOST_FULL_EN
    rbin_s        = gray2bin(rq2_q);
    fill_s        = wbin_d - rbin_s;
    almost_full_d = (fill_s >= PW'(ALMOST_FULL_THRESH));
`endif
  end

  // Pointer, synchronizer and flag registers
  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      wbin_q        <= {PW{1'b0}};
      wgray_q       <= {PW{1'b0}};
      rq1_q         <= {PW{1'b0}};
      rq2_q         <= {PW{1'b0}};
      full_q        <= 1'b0;
`ifdef GRAY_WPTR_CTRL_ALMOST_FULL_EN
      almost_full_q <= 1'b0;
`endif
    end else begin
      wbin_q        <= wbin_d;
      wgray_q       <= wgray_d;
      rq1_q         <= rq1_d;
      rq2_q         <= rq2_d;
      full_q        <= full_d;
`ifdef GRAY_WPTR_CTRL_ALMOST_FULL_EN
      almost_full_q <= almost_full_d;
`endif
    end
  end

  assign o_wen       = accept_s;
  assign o_waddr     = wbin_q[ADDR_WIDTH-1:0];
  assign o_wptr_gray = wgray_q;
  assign o_full      = full_q;
`ifdef GRAY_WPTR_CTRL_ALMOST_FULL_EN
  assign o_almost_full = almost_full_q;
`endif

endmodule

// File: doc/gray_wptr_ctrl.md
# gray_wptr_ctrl

Write-side pointer controller for an asynchronous FIFO. It owns the binary write pointer and gates write requests against full, and exports a registered Gray-coded write pointer for the read domain. It also synchronizes the read domain's Gray pointer into the write clock and derives full and, optionally, almost-full. It sits between the write requester and the FIFO storage RAM, next to the Gray encoder and decoder in the coders library.

## Interface

Parameters:
- ADDR_WIDTH, 4, storage address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
- ALMOST_FULL_THRESH, 2**ADDR_WIDTH-2, fill level at or above which o_almost_full asserts (used only with the macro)

Ports:
- i_clock  input  1  write-domain clock; all state on rising edge
- i_aresetn  input  1  reset, asynchronous assert, active-low
- i_push  input  1  write request from requester
- i_rptr_gray  input  ADDR_WIDTH+1  read pointer, Gray code, from the read clock domain (unsynchronized)
- o_wen  output  1  storage write enable = i_push & ~o_full (combinational)
- o_waddr  output  ADDR_WIDTH  storage write address = low ADDR_WIDTH bits of binary write pointer
- o_wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer for the read domain
- o_full  output  1  registered full flag
- o_almost_full  output  1  registered almost-full flag (present only with the macro)

## Operation

- State: binary write pointer wbin; registered Gray pointer wgray; two-flop synchronizer rq1, rq2 for i_rptr_gray; o_full; optional o_almost_full.
- Accept: a write is accepted in a cycle when i_push=1 and o_full=0. o_wen=1 and o_waddr=wbin[ADDR_WIDTH-1:0] in that cycle.
- wbin_next = wbin + accepted, modulo 2**(ADDR_WIDTH+1). The pointer wraps from all-ones to 0 with no special handling.
- wgray_next = gray(wbin_next), where gray(b)[i] = b[i]^b[i+1] and the MSB passes through unchanged. It is registered into o_wptr_gray, so the output only ever changes by one bit per cycle.
- Full: o_full <= (wgray_next == {~rq2[MSB], ~rq2[MSB-1], rq2[MSB-2:0]}).
- A push while o_full=1 is dropped: o_wen=0 and the pointer is unchanged. Requesters hold i_push until they see o_full low.
- Full is pessimistic. It deasserts only after a read-pointer advance has passed through the synchronizer. There is never a false not-full.
- Reset (i_aresetn low, any time, including mid-burst): wbin, o_wptr_gray, rq1, rq2, o_full and o_almost_full go to 0 immediately. o_wen follows combinationally: it is 0 while reset is held.

## Timing

- Write-accept latency: 0 cycles. o_wen is valid in the same cycle as i_push.
- o_wptr_gray updates on the edge that ends an accepting cycle.
- o_full rises on the same edge that accepts the write filling the FIFO. The next cycle shows o_full=1.
- A change on i_rptr_gray is captured in rq1 at edge 1 and rq2 at edge 2. o_full and o_almost_full reflect it at edge 3.
- Simultaneous push and read-pointer change: both are folded into the same next-state computation. Push is judged against the current registered o_full only.
- i_rptr_gray must change by at most one bit per read-domain cycle. The block does not check this.

## Configuration

- Macro: GRAY_WPTR_CTRL_ALMOST_FULL_EN.
- Defined: o_almost_full exists. The block decodes rq2 to binary rbin_s (gray-to-binary prefix XOR), computes fill = wbin_next - rbin_s modulo 2**(ADDR_WIDTH+1), and registers o_almost_full <= (fill >= ALMOST_FULL_THRESH). The port also goes to 0 on reset.
- Undefined: the port, the decoder and the subtractor are absent. Everything else is unchanged.

## Test plan

- Reset mid-burst: after 5 accepted pushes, pulse i_aresetn low -> o_wptr_gray=0, o_full=0, o_waddr=0 immediately, and push accepted at address 0 after release.
- Fill (ADDR_WIDTH=4, i_rptr_gray=0): 16 consecutive pushes -> o_waddr 0..15, o_wptr_gray sequence 0,1,3,2,6,7,5,4,12,… ending 5'b11000, o_full=1 after the 16th. A 17th push gives o_wen=0 and no pointer change.
- Drain release: from full, set i_rptr_gray=5'b00001 -> o_full still 1 for 2 cycles, 0 on 3rd edge. The next push is accepted at o_waddr=0 and o_full reasserts.
- Wrap: with i_rptr_gray tracking gray(wbin-1), 32 pushes -> o_wptr_gray goes 5'b10000 to 5'b00000 at the wrap. o_full never asserts and o_waddr wraps 15->0.
- Almost-full (macro defined, THRESH=14, rptr=0): o_almost_full=0 after 13 pushes, 1 after 14th. Advancing rptr by 1 (gray 5'b00001) clears it 3 edges later.
- Push blocked under full with simultaneous rptr advance: o_wen=0 during the 2 synchronizer cycles, then 1 once o_full drops.
